// File: rtl/memarb_pkg.sv
// Shared types for the two-port memory bus arbiter.
// Port 0 is the CPU and port 1 is the DMA master.
package memarb_pkg;

   localparam int NUM_PORTS = 2;

   typedef logic [$clog2(NUM_PORTS)-1:0] port_t;

   localparam port_t P_CPU = port_t'(0);
   localparam port_t P_DMA = port_t'(1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/memarb_pick.sv
// Winner selection between CPU and DMA requests: round-robin, or CPU-first with MEMARB_CPU_PRIORITY_EN.
// Latency: combinational, zero cycles.
// Backpressure: none here; the caller samples the result only while idle.
module memarb_pick
   import memarb_pkg::*;
(
   input  logic  i_req0,
   input  logic  i_req1,
   input  port_t i_last_grant,
   output logic  o_vld,
   output port_t o_port
);

   always_comb begin
      o_vld  = i_req0 | i_req1;
      o_port = P_CPU;
      if (i_req0 && i_req1) begin
`ifdef MEMARB_CPU_PRIORITY_EN
         o_port = P_CPU;
`else
         o_port = ~i_last_grant;
`endif
      end else if (i_req1) begin
         o_port = P_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU/DMA accesses onto one byte-wide memory bus; MEMARB_CPU_PRIORITY_EN makes the CPU win ties.
// Latency: write ack 2 cycles, read ack 3+(READ_LATENCY-1) cycles after the request is sampled in IDLE.
// Backpressure: requesters hold req until their one-cycle ack; the loser of a tie simply waits.
module mem_arbiter
   import memarb_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int AW           = 20,
   parameter int DW           = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          we0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   input  logic          we1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int CW = 3;

   state_t        r_state;
   port_t         r_port;
   port_t         r_last_grant;
   logic          r_we;
   logic [CW-1:0] r_cnt;

   logic          w_vld;
   port_t         w_port;

   memarb_pick u_pick (
      .i_req0       (req0),
      .i_req1       (req1),
      .i_last_grant (r_last_grant),
      .o_vld        (w_vld),
      .o_port       (w_port)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_port       <= P_CPU;
         r_last_grant <= P_DMA;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         rdata0       <= '0;
         rdata1       <= '0;
         mem_address  <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         mem_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_vld) begin
                  r_port       <= w_port;
                  r_last_grant <= w_port;
                  mem_address  <= (w_port == P_DMA) ? addr1  : addr0;
                  mem_wdata    <= (w_port == P_DMA) ? wdata1 : wdata0;
                  r_we         <= (w_port == P_DMA) ? we1    : we0;
                  // Strobe is registered here so it is high during GRANT only.
                  mem_we       <= (w_port == P_DMA) ? we1    : we0;
                  busy         <= 1'b1;
                  r_state      <= GRANT;
               end
            end
            GRANT: begin
               if (r_we) begin
                  ack0    <= (r_port == P_CPU);
                  ack1    <= (r_port == P_DMA);
                  r_state <= DONE;
               end else begin
                  r_cnt   <= CW'(READ_LATENCY - 1);
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  if (r_port == P_DMA) begin
                     rdata1 <= mem_rdata;
                  end else begin
                     rdata0 <= mem_rdata;
                  end
                  ack0    <= (r_port == P_CPU);
                  ack1    <= (r_port == P_DMA);
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model and per-cycle compare.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        req0, req1, we0, we1;
   logic [19:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        ack0, ack1, mem_we, busy;
   logic [7:0]  rdata0, rdata1, mem_wdata;
   logic [19:0] mem_address;
   logic [7:0]  mem_rdata;

   // Second instance with a 3-cycle memory.
   logic        c_req0, c_req1, c_we0, c_we1;
   logic [19:0] c_addr0, c_addr1;
   logic [7:0]  c_wdata0, c_wdata1;
   logic        c_ack0, c_ack1, c_mem_we, c_busy;
   logic [7:0]  c_rdata0, c_rdata1, c_mem_wdata;
   logic [19:0] c_mem_address;
   logic [7:0]  c_mem_rdata;
   logic [7:0]  c_p1, c_p2, c_p3;

   mem_arbiter #(.READ_LATENCY(1), .AW(20), .DW(8)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1), .rdata1(rdata1),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.READ_LATENCY(3), .AW(20), .DW(8)) dut3 (
      .clock(clock), .reset(reset),
      .req0(c_req0), .addr0(c_addr0), .wdata0(c_wdata0), .we0(c_we0), .ack0(c_ack0), .rdata0(c_rdata0),
      .req1(c_req1), .addr1(c_addr1), .wdata1(c_wdata1), .we1(c_we1), .ack1(c_ack1), .rdata1(c_rdata1),
      .mem_address(c_mem_address), .mem_wdata(c_mem_wdata), .mem_we(c_mem_we),
      .mem_rdata(c_mem_rdata), .busy(c_busy)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] mem_f(input logic [19:0] a);
      case (a)
         20'h00010: return 8'hA5;
         20'hF8000: return 8'h3C;
         default:   return a[7:0] ^ a[19:12] ^ 8'h5A;
      endcase
   endfunction

   always @(posedge clock) mem_rdata <= mem_f(mem_address);
   always @(posedge clock) begin
      c_p1 <= mem_f(c_mem_address);
      c_p2 <= c_p1;
      c_p3 <= c_p2;
   end
   assign c_mem_rdata = c_p3;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a granted transaction occupies m_len cycles after the sampling edge,
   // with the strobe in its first cycle and the ack in its last.
   int          m_phase, m_len;
   bit          m_last, m_port, m_we;
   logic [19:0] m_addr;
   logic [7:0]  m_wd;
   logic        e_ack0, e_ack1, e_we, e_busy;
   logic [19:0] e_addr;
   logic [7:0]  e_wd, e_rd0, e_rd1;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_phase = 0; m_len = 0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wd = '0;
         e_ack0 = 0; e_ack1 = 0; e_we = 0; e_busy = 0;
         e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
      end else begin
         if (m_phase != 0) begin
            if (m_phase == m_len) m_phase = 0;
            else m_phase = m_phase + 1;
         end else if (req0 || req1) begin
            if (req0 && req1) begin
`ifdef MEMARB_CPU_PRIORITY_EN
               m_port = 1'b0;
`else
               m_port = !m_last;
`endif
            end else begin
               m_port = req1;
            end
            m_last  = m_port;
            m_addr  = m_port ? addr1  : addr0;
            m_wd    = m_port ? wdata1 : wdata0;
            m_we    = m_port ? we1    : we0;
            m_len   = m_we ? 2 : 3;
            m_phase = 1;
         end
         e_busy = (m_phase != 0);
         e_we   = (m_phase == 1) && m_we;
         e_ack0 = (m_phase != 0) && (m_phase == m_len) && !m_port;
         e_ack1 = (m_phase != 0) && (m_phase == m_len) &&  m_port;
         if (e_ack0 && !m_we) e_rd0 = mem_f(m_addr);
         if (e_ack1 && !m_we) e_rd1 = mem_f(m_addr);
         e_addr = m_addr;
         e_wd   = m_wd;
      end
   end

   int          a0_cnt = 0, a1_cnt = 0, we_cnt = 0;
   logic [19:0] we_addr;
   logic [7:0]  we_dat;

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("ack0", ack0, e_ack0);
         chk("ack1", ack1, e_ack1);
         chk("mem_we", mem_we, e_we);
         chk("busy", busy, e_busy);
         chk("mem_address", mem_address, e_addr);
         chk("mem_wdata", mem_wdata, e_wd);
         chk("rdata0", rdata0, e_rd0);
         chk("rdata1", rdata1, e_rd1);
         if (ack0) a0_cnt++;
         if (ack1) a1_cnt++;
         if (mem_we) begin
            we_cnt++;
            we_addr = mem_address;
            we_dat  = mem_wdata;
         end
      end
   end

   task automatic wait_ack(input int port, input int t0, output int lat, output logic [7:0] rd);
      lat = -1;
      rd  = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if ((port == 0 && ack0) || (port == 1 && ack1)) begin
            lat = cyc - t0;
            rd  = (port == 1) ? rdata1 : rdata0;
            break;
         end
      end
      if (lat < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ack%0d_timeout: got no ack, expected one within 40 cycles", port);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected end of test");
      $fatal(1, "bench timeout");
   end

   int          lat, t0, a0_before, a1_before, nack;
   logic [7:0]  rd;
   int          ord [6];
   int          exp_ord [6];

   initial begin
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      c_req0 = 0; c_req1 = 0; c_we0 = 0; c_we1 = 0;
      c_addr0 = '0; c_addr1 = '0; c_wdata0 = '0; c_wdata1 = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      cmp_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_ack0", ack0, 0);

      // CPU read of 0x00010.
      @(posedge clock); #1;
      req0 = 1; addr0 = 20'h00010; we0 = 0; wdata0 = 8'h77; t0 = cyc;
      wait_ack(0, t0, lat, rd);
      chk("rd_latency", lat, 3);
      chk("rd_data", rd, 8'hA5);
      @(posedge clock); #1;
      req0 = 0;
      repeat (2) @(posedge clock); #1;
      chk("rd_no_ack1", a1_cnt, 0);
      chk("rd_no_we", we_cnt, 0);

      // DMA write to 0xB8002.
      req1 = 1; addr1 = 20'hB8002; we1 = 1; wdata1 = 8'h41; t0 = cyc;
      wait_ack(1, t0, lat, rd);
      chk("wr_latency", lat, 2);
      @(posedge clock); #1;
      req1 = 0; we1 = 0;
      repeat (2) @(posedge clock); #1;
      chk("wr_we_pulses", we_cnt, 1);
      chk("wr_we_addr", we_addr, 20'hB8002);
      chk("wr_we_data", we_dat, 8'h41);

      // Both ports requesting reads continuously.
`ifdef MEMARB_CPU_PRIORITY_EN
      exp_ord = '{0, 0, 0, 0, 0, 0};
`else
      exp_ord = '{0, 1, 0, 1, 0, 1};
`endif
      req0 = 1; addr0 = 20'h00010; we0 = 0;
      req1 = 1; addr1 = 20'h03456; we1 = 0;
      nack = 0;
      for (int i = 0; i < 80 && nack < 6; i++) begin
         @(negedge clock);
         if (ack0 || ack1) begin
            ord[nack] = ack1 ? 1 : 0;
            nack++;
         end
      end
      @(posedge clock); #1;
      req0 = 0; req1 = 0;
      chk("rr_ack_count", nack, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("rr_order_%0d", i), ord[i], exp_ord[i]);
      chk("rr_rdata0", rdata0, 8'hA5);
`ifdef MEMARB_CPU_PRIORITY_EN
      chk("rr_rdata1", rdata1, 8'h00);
`else
      chk("rr_rdata1", rdata1, 8'h0F);
`endif

      // Three-cycle memory read at 0xF8000.
      c_req0 = 1; c_addr0 = 20'hF8000; c_we0 = 0; t0 = cyc;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (c_ack0) begin
            lat = cyc - t0;
            chk("rl3_data", c_rdata0, 8'h3C);
            break;
         end
      end
      chk("rl3_latency", lat, 5);
      @(posedge clock); #1;
      c_req0 = 0;

      // Reset asserted during the WAIT cycle of a DMA read.
      @(posedge clock); #1;
      a1_before = a1_cnt;
      req1 = 1; addr1 = 20'h0020A; we1 = 0; t0 = cyc;
      @(posedge clock);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_mem_we", mem_we, 0);
      chk("arst_ack1", ack1, 0);
      chk("arst_rdata1", rdata1, 0);
      chk("arst_mem_address", mem_address, 0);
      req1 = 0;
      repeat (2) @(posedge clock); #1;
      reset = 1'b0;
      chk("arst_no_ack1", a1_cnt, a1_before);
      req0 = 1; addr0 = 20'h00010; we0 = 0;
      req1 = 1; addr1 = 20'h0020A; we1 = 0; t0 = cyc;
      wait_ack(0, t0, lat, rd);
      chk("post_rst_first_lat", lat, 3);
      chk("post_rst_first_data", rd, 8'hA5);
      @(posedge clock); #1;
      req0 = 0;
      wait_ack(1, t0, lat, rd);
      chk("post_rst_second_lat", lat, 7);
      chk("post_rst_second_data", rd, 8'h50);
      @(posedge clock); #1;
      req1 = 0;

      // Request dropped and address changed while the read is in flight.
      @(posedge clock); #1;
      a0_before = a0_cnt;
      req0 = 1; addr0 = 20'h00777; we0 = 0; t0 = cyc;
      @(posedge clock);
      @(posedge clock); #1;
      req0 = 0; addr0 = 20'h12345;
      wait_ack(0, t0, lat, rd);
      chk("drop_latency", lat, 3);
      chk("drop_data", rd, 8'h2D);
      chk("drop_address", mem_address, 20'h00777);
      repeat (8) @(posedge clock); #1;
      chk("drop_single_ack", a0_cnt, a0_before + 1);
      chk("drop_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 20-bit byte-wide system memory bus between two requesters: the CPU (port 0) and a DMA master (port 1), e.g. SD-card or disk DMA.
- Sits between the requesters and the address-decode/routing mux that fronts main memory, CGA memory and BIOS.
- Serialises accesses, drives one bus transaction at a time, waits out the synchronous-RAM read latency, and returns captured data with a one-cycle ack per requester.

Parameters:
- READ_LATENCY, 1: cycles from address presentation to valid mem_rdata; range 1..7.
- AW, 20: address width.
- DW, 8: data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  CPU request; held high until ack0.
- addr0  in  AW  CPU address; stable while req0 is high.
- wdata0  in  DW  CPU write data.
- we0  in  1  CPU write (1) or read (0).
- ack0  out  1  one-cycle completion pulse to CPU.
- rdata0  out  DW  CPU read data; valid when ack0 is high, held until the next ack0.
- req1, addr1, wdata1, we1, ack1, rdata1: same signals for the DMA port.
- mem_address  out  AW  bus address.
- mem_wdata  out  DW  bus write data.
- mem_we  out  1  bus write strobe.
- mem_rdata  in  DW  routed read data from the decode mux.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: ack0, ack1, mem_we and busy are 0. mem_address, mem_wdata, rdata0 and rdata1 are 0. State is IDLE. last_grant is 1, so port 0 wins the first tie.
- All outputs are registered.
- States:
  - IDLE: sample req0 and req1. If neither is high, stay. If exactly one is high, grant it. If both are high, grant the port that is not last_grant (round-robin). Latch the granted port's address, wdata and we into mem_address, mem_wdata and the internal we. Set last_grant to the granted port. Go to GRANT.
  - GRANT: mem_address is valid. mem_we equals the latched we for this cycle only. A write goes to DONE. A read loads the wait counter with READ_LATENCY-1 and goes to WAIT.
  - WAIT: the counter decrements each cycle. When the counter is 0, capture mem_rdata into the granted port's rdata and go to DONE. mem_we is 0.
  - DONE: the granted port's ack is high for exactly this cycle, and the other ack stays 0. Go to IDLE.
- mem_address holds its last value in IDLE. mem_we is 0 outside GRANT.
- Latency from req sampled in IDLE to ack high:
  - read: 3+(READ_LATENCY-1) cycles, i.e. 3 cycles at the default.
  - write: 2 cycles.
- Handshake:
  - A requester drops req on the edge that ends its ack cycle. The IDLE cycle after DONE then sees the updated req.
  - A req still high in that IDLE cycle is a new transaction.
  - Dropping req after grant does not abort: the transaction completes and ack still pulses.
  - Changing addr, wdata or we after grant has no effect.
- Starvation bound: with both ports requesting continuously, grants strictly alternate 0,1,0,1…
- The read of port N never updates rdata of the other port.
- Asynchronous reset mid-transaction: mem_we drops immediately, the pending transaction is discarded with no ack, and all outputs take their reset values.

Optional Feature:
- Macro: MEMARB_CPU_PRIORITY_EN.
- Defined: port 0 always wins when both ports request. last_grant is still updated but ignored.
- Undefined: round-robin as above.

Decomposition:
- Package memarb_pkg holds:
  - the state enum {IDLE, GRANT, WAIT, DONE};
  - the port index type;
  - the constant NUM_PORTS=2.
- One sub-module, memarb_pick: combinational winner selection from req0, req1, last_grant and the macro. It keeps the priority policy swappable.

Test Plan:
- Reset, then req0 read at 0x00010 with mem_rdata model returning 0xA5 one cycle after the address -> ack0 3 cycles after req sampled, rdata0=0xA5, ack1 never high, mem_we never high.
- req1 write addr 0xB8002 data 0x41 -> mem_we high exactly 1 cycle with mem_address=0xB8002 and mem_wdata=0x41, ack1 2 cycles after sample.
- req0 and req1 both held high for 6 reads -> grant order 0,1,0,1,0,1. Under MEMARB_CPU_PRIORITY_EN, 0,0,0… with port 1 starved.
- READ_LATENCY=3: read at 0xF8000 -> ack 5 cycles after sample, and mem_rdata is captured on the 3rd cycle after GRANT, not earlier.
- Assert reset during WAIT of a port-1 read -> no ack1, busy=0 immediately, rdata1=0. The next req0 is served normally with port 0 granted first.
- req0 dropped during WAIT and addr0 changed to 0x12345 -> transaction completes at the original address, ack0 pulses once, and no second transaction starts.
